fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side adapter between the single-clock FIFO (FIFO-2N) and a valid/ready stream consumer.
//  Pops the FIFO's show-ahead read port into a 2-entry registered output buffer.
//  Sustains 1 beat/clk with no combinational path from i_ready to o_fifo_rden.
//  Also provides a synchronous flush, an idle flag and a delivered-beat counter.
// PARAMETERS
//  DATA_W  4   data width; must equal the FIFO DATA_W
//  CNT_W   16  width of the delivered-beat counter
// PORTS
//  clk            in   1       clock; all flops rise-edge
//  rst            in   1       reset, asynchronous, active-high
//  i_fifo_empty   in   1       FIFO o_empty
//  i_fifo_rddata  in   DATA_W  FIFO o_rddata; combinational, valid when !i_fifo_empty
//  o_fifo_rden    out  1       FIFO i_rden (pop)
//  o_valid        out  1       stream data valid
//  o_data         out  DATA_W  stream data (registered)
//  i_ready        in   1       stream consumer ready
//  i_flush        in   1       drop all buffered beats (FIFO contents untouched)
//  o_idle         out  1       buffer empty and FIFO empty
//  o_beat_cnt     out  CNT_W   count of completed stream handshakes
// BEHAVIOUR
//  - Reset (async assert, sync release): occ=0, head/skid=0, o_valid=0, o_data=0, o_beat_cnt=0.
//    o_fifo_rden is forced to 0 while rst=1.
//  - Storage: head reg (drives o_data) plus skid reg; occupancy occ in 0..2.
//  - o_valid = (occ!=0); deq = o_valid & i_ready.
//  - pop = o_fifo_rden = !rst & !i_fifo_empty & !i_flush & (occ<2).
//    Depends on registered occ only, never on i_ready.
//  - On pop, i_fifo_rddata is captured at the same edge at which the FIFO advances rdptr.
//  - Update rules, in order (head always holds the oldest beat):
//    - occ=0: pop -> head<=data, occ=1.
//    - occ=1:
//      - deq&pop -> head<=data, occ=1
//      - pop only -> skid<=data, occ=2
//      - deq only -> occ=0
//    - occ=2 (no pop): deq -> head<=skid, occ=1.
//  - Latency: i_fifo_empty falling at edge N -> o_valid=1 after edge N+1.
//    FIFO write to o_valid is therefore 2 clk.
//  - Throughput: with i_ready held high, occ settles at 1 and 1 beat/clk flows.
//  - Backpressure: while o_valid & !i_ready, o_data and o_valid stay stable.
//    The buffer fills to 2, then pops stop.
//  - Boundary: FIFO empty -> no pop, so a pop on empty never occurs.
//    occ=2 -> no pop, so a buffer overflow never occurs.
//  - Flush: i_flush=1 suppresses pop that cycle. If deq coincides, that beat completes and is counted.
//    At the next edge occ<=0, so o_valid=0. head/skid keep stale data (don't-care).
//  - o_beat_cnt += 1 on every deq; wraps modulo 2^CNT_W with no saturation.
//  - o_idle = (occ==0) & i_fifo_empty; combinational.
//  - Reset mid-transfer: buffered beats are lost. The FIFO (sync reset) must be reset in the same window.
// TESTING
//  1. Reset, write A5 into FIFO, i_ready=1 -> o_valid high 2 clk after write, o_data=A5, o_beat_cnt=1.
//  2. Write 8 words 0..7 back-to-back, i_ready=1 -> o_data=0..7 on consecutive clks, no gaps, cnt=8.
//  3. FIFO full (8 words), i_ready=0 for 5 clk -> exactly 2 pops, o_data=0 stable.
//     Release -> 0..7 in order.
//  4. i_ready toggled 1/0 each clk over 6 words -> in-order output, no loss/duplicates, occ never >2.
//  5. occ=2 (words 3,4), assert i_flush with i_ready=1 -> 3 delivered (cnt+1), o_valid=0 next clk.
//     Next FIFO word 5 appears after that.
//  6. CNT_W=4, pass 17 beats -> o_beat_cnt=1. Assert rst with occ=2 -> o_valid=0 and o_fifo_rden=0 immediately.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// Read-side stream adapter bundle: FIFO show-ahead port, valid/ready stream, flush and status.
// The master modport is the adapter's view; the slave modport is the FIFO/consumer side.
interface fifo_rd_stream_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
);
    logic              i_fifo_empty;
    logic [DATA_W-1:0] i_fifo_rddata;
    logic              o_fifo_rden;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              i_ready;
    logic              i_flush;
    logic              o_idle;
    logic [CNT_W-1:0]  o_beat_cnt;

    modport master (
        input  i_fifo_empty,
        input  i_fifo_rddata,
        input  i_ready,
        input  i_flush,
        output o_fifo_rden,
        output o_valid,
        output o_data,
        output o_idle,
        output o_beat_cnt
    );

    modport slave (
        output i_fifo_empty,
        output i_fifo_rddata,
        output i_ready,
        output i_flush,
        input  o_fifo_rden,
        input  o_valid,
        input  o_data,
        input  o_idle,
        input  o_beat_cnt
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Pops a show-ahead FIFO into a 2-entry registered head/skid buffer feeding a valid/ready stream.
// Latency: FIFO non-empty at edge N gives o_valid after edge N+1; sustains 1 beat/clk.
// Backpressure: head holds while stalled, skid absorbs one beat, pops stop at occupancy 2.
module fifo_rd_stream #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    fifo_rd_stream_if.master  bus
);

    typedef enum logic [1:0] {
        OCC0 = 2'd0,
        OCC1 = 2'd1,
        OCC2 = 2'd2
    } occ_t;

    occ_t              state_q, state_d;
    logic [DATA_W-1:0] head_q,  head_d;
    logic [DATA_W-1:0] skid_q,  skid_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              pop;
    logic              deq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OCC0;
            head_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pop decision uses registered occupancy only, so i_ready never reaches o_fifo_rden.
    always_comb begin
        pop     = !rst && !bus.i_fifo_empty && !bus.i_flush && (state_q != OCC2);
        deq     = (state_q != OCC0) && bus.i_ready;
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q + CNT_W'(deq);

        if (bus.i_flush) begin
            state_d = OCC0;
        end else begin
            unique case (state_q)
                OCC0: begin
                    if (pop) begin
                        head_d  = bus.i_fifo_rddata;
                        state_d = OCC1;
                    end
                end
                OCC1: begin
                    if (deq && pop) begin
                        head_d  = bus.i_fifo_rddata;
                    end else if (pop) begin
                        skid_d  = bus.i_fifo_rddata;
                        state_d = OCC2;
                    end else if (deq) begin
                        state_d = OCC0;
                    end
                end
                OCC2: begin
                    if (deq) begin
                        head_d  = skid_q;
                        state_d = OCC1;
                    end
                end
                default: state_d = OCC0;
            endcase
        end
    end

    assign bus.o_fifo_rden = pop;
    assign bus.o_valid     = (state_q != OCC0);
    assign bus.o_data      = head_q;
    assign bus.o_idle      = (state_q == OCC0) && bus.i_fifo_empty;
    assign bus.o_beat_cnt  = cnt_q;

    a_no_pop_on_empty: assert property (@(posedge clk) disable iff (rst)
        !(bus.o_fifo_rden && bus.i_fifo_empty));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized and directed stimulus against a queue-based model of the FIFO plus adapter buffer.
module tb_fifo_rd_stream;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 4;
    localparam int FIFO_DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    fifo_rd_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] buf_q[$];   // beats popped out of the FIFO, not yet delivered
    int unsigned       beats = 0;
    int                n_checks = 0;
    int                n_errors = 0;
    int                rden_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_fifo_port();
        bus.i_fifo_empty  = (fifo_q.size() == 0);
        bus.i_fifo_rddata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    // One clock: apply inputs, check outputs mid-cycle, advance the model across the edge.
    task automatic cycle(input bit wr, input logic [DATA_W-1:0] wdat, input bit rdy, input bit fl);
        bit exp_rden;
        bit exp_vld;
        bus.i_ready = rdy;
        bus.i_flush = fl;
        @(negedge clk);
        exp_rden = !rst && (fifo_q.size() != 0) && !fl && (buf_q.size() < 2);
        exp_vld  = (buf_q.size() != 0);
        check_val("rden", 32'(bus.o_fifo_rden), 32'(exp_rden));
        check_val("valid", 32'(bus.o_valid), 32'(exp_vld));
        if (exp_vld) check_val("data", 32'(bus.o_data), 32'(buf_q[0]));
        check_val("idle", 32'(bus.o_idle), 32'((buf_q.size() == 0) && (fifo_q.size() == 0)));
        check_val("beat_cnt", 32'(bus.o_beat_cnt), beats % (1 << CNT_W));
        if (bus.o_fifo_rden) rden_seen++;
        if (exp_vld && rdy) begin
            void'(buf_q.pop_front());
            beats++;
        end
        if (fl) buf_q.delete();
        if (exp_rden) buf_q.push_back(fifo_q.pop_front());
        if (wr && fifo_q.size() < FIFO_DEPTH) fifo_q.push_back(wdat);
        @(posedge clk);
        #1;
        drive_fifo_port();
    endtask

    // Asynchronous reset asserted mid-cycle; FIFO is reset in the same window.
    task automatic reset_now();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_valid", 32'(bus.o_valid), 32'd0);
        check_val("rst_rden", 32'(bus.o_fifo_rden), 32'd0);
        check_val("rst_cnt", 32'(bus.o_beat_cnt), 32'd0);
        check_val("rst_data", 32'(bus.o_data), 32'd0);
        buf_q.delete();
        fifo_q.delete();
        beats = 0;
        @(posedge clk);
        #1;
        drive_fifo_port();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.i_ready       = 1'b0;
        bus.i_flush       = 1'b0;
        bus.i_fifo_empty  = 1'b0;
        bus.i_fifo_rddata = 8'h3C;
        #12;
        // Reset state, with a non-empty FIFO presented to prove pops are gated off
        check_val("init_rden", 32'(bus.o_fifo_rden), 32'd0);
        check_val("init_valid", 32'(bus.o_valid), 32'd0);
        check_val("init_data", 32'(bus.o_data), 32'd0);
        check_val("init_cnt", 32'(bus.o_beat_cnt), 32'd0);
        drive_fifo_port();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: single word, 2-clk write-to-valid latency
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        check_val("t1_not_yet", 32'(bus.o_valid), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_val("t1_valid", 32'(bus.o_valid), 32'd1);
        check_val("t1_data", 32'(bus.o_data), 32'hA5);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_val("t1_cnt", 32'(bus.o_beat_cnt), 32'd1);

        // 2: back-to-back stream with ready held high
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
        check_val("t2_cnt", 32'(bus.o_beat_cnt), 32'd9);

        // 3: stalled consumer, only two pops may happen
        rden_seen = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        repeat (5) cycle(1'b0, '0, 1'b0, 1'b0);
        check_val("t3_pops", 32'(rden_seen), 32'd2);
        check_val("t3_head", 32'(bus.o_data), 32'd0);
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b0);

        // 4: ready toggling every clock
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h10 + i), i[0], 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, i[0], 1'b0);

        // 5: flush with two beats buffered and a deq in the same cycle
        for (int i = 3; i < 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_val("t5_head", 32'(bus.o_data), 32'd3);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check_val("t5_flushed", 32'(bus.o_valid), 32'd0);
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b0);

        // 6: counter wrap at CNT_W=4, then reset with a full buffer
        reset_now();
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
        check_val("t6_wrap", 32'(bus.o_beat_cnt), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        check_val("t6_full_buf", 32'(bus.o_valid), 32'd1);
        reset_now();

        // Random traffic with occasional flush and reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_now();
            end else begin
                cycle(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 65),
                      ($urandom_range(0, 29) == 0));
            end
        end
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b0);
        check_val("drain_idle", 32'(bus.o_idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
